reg_file_sb: RTL

Parametrised general-purpose register file with an integrated per-register busy scoreboard, for the multi-cycle and pipelined MIPS cores. Provides NRD combinational read ports, one synchronous write port, and a busy bit per register that is set when a producing instruction issues and cleared when its result is written back. Register 0 is hard-wired to zero and never busy. The core's issue logic uses the per-port busy outputs to stall on read-after-write hazards.

---
 rtl/reg_file_pkg.sv | 21 ++
 rtl/reg_file_rd_port.sv | 66 ++++++
 rtl/reg_file_sb.sv | 133 +++++++++++++
 3 files changed

// File: rtl/reg_file_pkg.sv
// -----------------------------------------------------------------------------
// reg_file_pkg
// Shared definitions for the register file / busy scoreboard slice.
//   DATA_WIDTH_DEF : default register width in bits
//   ADDR_WIDTH_DEF : default register address width (32 registers)
//   REG_ZERO       : architectural zero-register address
//   reg_addr_t     : register address at default width
//   reg_data_t     : register data word at default width
// Optional feature macro used by the importing files: REG_FILE_BYPASS_EN.
// -----------------------------------------------------------------------------
package reg_file_pkg;

  localparam int unsigned DATA_WIDTH_DEF = 32;
  localparam int unsigned ADDR_WIDTH_DEF = 5;

  typedef logic [ADDR_WIDTH_DEF-1:0] reg_addr_t;
  typedef logic [DATA_WIDTH_DEF-1:0] reg_data_t;

  localparam reg_addr_t REG_ZERO = '0;

endpackage

// File: rtl/reg_file_rd_port.sv
// -----------------------------------------------------------------------------
// reg_file_rd_port
// One combinational read port of the register file: selects a data word and
// its busy bit, masks register 0 to zero / never-busy, and (when
// REG_FILE_BYPASS_EN is defined) forwards a same-cycle writeback to the reader.
// Ports:
//   regs_i   : full data array (REG_UNITS words)
//   busy_i   : busy bit per register
//   raddr_i  : read address for this port
//   wen_i    : writeback enable   (used only for bypass)
//   waddr_i  : writeback address  (used only for bypass)
//   wdata_i  : writeback data     (used only for bypass)
//   rdata_o  : read data
//   rbusy_o  : busy bit of the addressed register
// Macro: REG_FILE_BYPASS_EN enables write-through forwarding.
// -----------------------------------------------------------------------------
module reg_file_rd_port
  import reg_file_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = DATA_WIDTH_DEF,
  parameter int unsigned ADDR_WIDTH = ADDR_WIDTH_DEF,
  localparam int unsigned REG_UNITS = 2**ADDR_WIDTH
) (
  input  logic [DATA_WIDTH-1:0] regs_i [REG_UNITS],
  input  logic [REG_UNITS-1:0]  busy_i,
  input  logic [ADDR_WIDTH-1:0] raddr_i,
  input  logic                  wen_i,
  input  logic [ADDR_WIDTH-1:0] waddr_i,
  input  logic [DATA_WIDTH-1:0] wdata_i,
  output logic [DATA_WIDTH-1:0] rdata_o,
  output logic                  rbusy_o
);

  logic                  zero_sel;
  logic [DATA_WIDTH-1:0] arr_data;
  logic                  arr_busy;

  // Register 0 reads as zero and is never busy, independent of array contents.
  always_comb begin
    zero_sel = (raddr_i == '0);
    arr_data = zero_sel ? '0   : regs_i[raddr_i];
    arr_busy = zero_sel ? 1'b0 : busy_i[raddr_i];
  end

`ifdef REG_FILE_BYPASS_EN
  logic hit;

  // A writeback to the register being read completes this cycle: forward its
  // data and report not-busy. A same-cycle busy set is deliberately ignored.
  always_comb begin
    hit     = wen_i && (waddr_i != '0) && (waddr_i == raddr_i);
    rdata_o = hit ? wdata_i : arr_data;
    rbusy_o = hit ? 1'b0    : arr_busy;
  end
`else
  logic unused_bypass;

  assign unused_bypass = ^{wen_i, waddr_i, wdata_i};

  always_comb begin
    rdata_o = arr_data;
    rbusy_o = arr_busy;
  end
`endif

endmodule

// File: rtl/reg_file_sb.sv
// -----------------------------------------------------------------------------
// reg_file_sb
// General-purpose register file with a per-register busy scoreboard for RAW
// hazard stalling. NRD combinational read ports, one synchronous write port.
// Register 0 is hard-wired to zero and never busy.
// Ports:
//   clk      : clock, all state updates on rising edge
//   rst      : asynchronous active-high reset
//   wen      : writeback enable (writes data, clears busy)
//   waddr    : writeback address
//   wdata    : writeback data
//   set_en   : mark set_addr busy (producer issued)
//   set_addr : register to mark busy
//   raddr    : packed read addresses, port i at [i*ADDR_WIDTH +: ADDR_WIDTH]
//   ren      : per-port read-valid, qualifies stall only
//   rdata    : packed read data, port i at [i*DATA_WIDTH +: DATA_WIDTH]
//   rbusy    : busy bit of the register addressed by each port
//   stall    : OR over ports of (ren & rbusy)
//   busy_cnt : registered number of busy registers
// Macro: REG_FILE_BYPASS_EN enables same-cycle writeback forwarding on reads.
// -----------------------------------------------------------------------------
module reg_file_sb
  import reg_file_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = DATA_WIDTH_DEF,
  parameter int unsigned ADDR_WIDTH = ADDR_WIDTH_DEF,
  parameter int unsigned NRD        = 2
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      wen,
  input  logic [ADDR_WIDTH-1:0]     waddr,
  input  logic [DATA_WIDTH-1:0]     wdata,
  input  logic                      set_en,
  input  logic [ADDR_WIDTH-1:0]     set_addr,
  input  logic [NRD*ADDR_WIDTH-1:0] raddr,
  input  logic [NRD-1:0]            ren,
  output logic [NRD*DATA_WIDTH-1:0] rdata,
  output logic [NRD-1:0]            rbusy,
  output logic                      stall,
  output logic [ADDR_WIDTH:0]       busy_cnt
);

  localparam int unsigned REG_UNITS = 2**ADDR_WIDTH;

  logic [DATA_WIDTH-1:0] regs_q [REG_UNITS];
  logic [REG_UNITS-1:0]  busy_q;
  logic [REG_UNITS-1:0]  busy_d;
  logic [ADDR_WIDTH:0]   cnt_q;
  logic [ADDR_WIDTH:0]   cnt_d;
  logic                  wr_en;
  logic                  set_ok;

  always_comb begin
    wr_en  = wen    && (waddr    != '0);
    set_ok = set_en && (set_addr != '0);
  end

  // ---------------------------------------------------------------------------
  // Data array
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int unsigned i = 0; i < REG_UNITS; i++) begin
        regs_q[i] <= '0;
      end
    end else if (wr_en) begin
      regs_q[waddr] <= wdata;
    end
  end

  // ---------------------------------------------------------------------------
  // Busy scoreboard: clear applied before set so a new producer issued in the
  // same cycle as the old one retires keeps the register busy.
  // ---------------------------------------------------------------------------
  always_comb begin
    busy_d = busy_q;
    if (wr_en) begin
      busy_d[waddr] = 1'b0;
    end
    if (set_ok) begin
      busy_d[set_addr] = 1'b1;
    end
    busy_d[0] = 1'b0;
  end

  // Count taken from the next-state vector so busy_cnt tracks busy_q exactly.
  always_comb begin
    cnt_d = '0;
    for (int unsigned i = 0; i < REG_UNITS; i++) begin
      cnt_d = cnt_d + {{ADDR_WIDTH{1'b0}}, busy_d[i]};
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      busy_q <= '0;
      cnt_q  <= '0;
    end else begin
      busy_q <= busy_d;
      cnt_q  <= cnt_d;
    end
  end

  assign busy_cnt = cnt_q;

  // ---------------------------------------------------------------------------
  // Read ports
  // ---------------------------------------------------------------------------
  for (genvar g = 0; g < NRD; g++) begin : g_rd
    reg_file_rd_port #(
      .DATA_WIDTH (DATA_WIDTH),
      .ADDR_WIDTH (ADDR_WIDTH)
    ) u_rd_port (
      .regs_i  (regs_q),
      .busy_i  (busy_q),
      .raddr_i (raddr[g*ADDR_WIDTH +: ADDR_WIDTH]),
      .wen_i   (wen),
      .waddr_i (waddr),
      .wdata_i (wdata),
      .rdata_o (rdata[g*DATA_WIDTH +: DATA_WIDTH]),
      .rbusy_o (rbusy[g])
    );
  end

  always_comb begin
    stall = 1'b0;
    for (int unsigned i = 0; i < NRD; i++) begin
      stall = stall | (ren[i] & rbusy[i]);
    end
  end

endmodule
